// File: rtl/cxt_rsp_reorder_buffer_if.sv
// Valid/ready bundle carrying one context response (head + payload).
// Shared by the out-of-order input side and the in-order release side.
interface cxt_rsp_reorder_buffer_if #(
    parameter int HEAD_WIDTH = 16,
    parameter int DATA_WIDTH = 64
);
    logic                  valid;
    logic [HEAD_WIDTH-1:0] head;
    logic [DATA_WIDTH-1:0] data;
    logic                  ready;

    modport master (
        output valid,
        output head,
        output data,
        input  ready
    );

    modport slave (
        input  valid,
        input  head,
        input  data,
        output ready
    );
endinterface

// File: rtl/cxt_rsp_reorder_buffer.sv
// Parks out-of-order context responses by tag and releases them
// strictly in tag order through a registered output stage.
module cxt_rsp_reorder_buffer #(
    parameter int REQ_TAG_NUM     = 32,
    parameter int REQ_TAG_NUM_LOG = $clog2(REQ_TAG_NUM),
    parameter int HEAD_WIDTH      = 16,
    parameter int DATA_WIDTH      = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    cxt_rsp_reorder_buffer_if.slave    cxt_rsp,
    cxt_rsp_reorder_buffer_if.master   cxt_combine,
    output logic [REQ_TAG_NUM_LOG-1:0] rd_ptr,
    output logic [REQ_TAG_NUM_LOG:0]   occupancy
);
    typedef logic [REQ_TAG_NUM_LOG-1:0] tag_t;

    logic [HEAD_WIDTH-1:0]  head_mem [REQ_TAG_NUM];
    logic [DATA_WIDTH-1:0]  data_mem [REQ_TAG_NUM];
    logic [REQ_TAG_NUM-1:0] slot_valid;
    logic [REQ_TAG_NUM-1:0] slot_valid_nxt;

    tag_t                  in_tag;
    logic                  accept;
    logic                  load_en;
    logic                  out_valid;
    logic                  out_fire;
    logic [HEAD_WIDTH-1:0] out_head;
    logic [DATA_WIDTH-1:0] out_data;

    assign in_tag = cxt_rsp.head[REQ_TAG_NUM_LOG-1:0];

    // An occupied slot stalls its tag; a parked response is never overwritten.
    assign cxt_rsp.ready = ~slot_valid[in_tag];
    assign accept        = cxt_rsp.valid & cxt_rsp.ready;

    assign out_fire = out_valid & cxt_combine.ready;
    assign load_en  = slot_valid[rd_ptr]
                    & (~out_valid | cxt_combine.ready);

    always_ff @(posedge clk) begin
        if (accept) begin
            head_mem[in_tag] <= cxt_rsp.head;
            data_mem[in_tag] <= cxt_rsp.data;
        end
    end

    // Set and clear never hit the same slot: a valid slot refuses writes.
    always_comb begin
        slot_valid_nxt = slot_valid;
        if (load_en) begin
            slot_valid_nxt[rd_ptr] = 1'b0;
        end
        if (accept) begin
            slot_valid_nxt[in_tag] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot_valid <= '0;
        end else begin
            slot_valid <= slot_valid_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr <= '0;
        end else if (load_en) begin
            rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            occupancy <= '0;
        end else begin
            unique case ({accept, load_en})
                2'b10:   occupancy <= occupancy + 1'b1;
                2'b01:   occupancy <= occupancy - 1'b1;
                default: occupancy <= occupancy;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_head  <= '0;
            out_data  <= '0;
        end else if (load_en) begin
            out_valid <= 1'b1;
            out_head  <= head_mem[rd_ptr];
            out_data  <= data_mem[rd_ptr];
        end else if (out_fire) begin
            out_valid <= 1'b0;
        end
    end

    assign cxt_combine.valid = out_valid;
    assign cxt_combine.head  = out_head;
    assign cxt_combine.data  = out_data;

    a_occ_range: assert property (
        @(posedge clk) disable iff (!rst_n)
        int'(occupancy) <= REQ_TAG_NUM
    );

    a_occ_count: assert property (
        @(posedge clk) disable iff (!rst_n)
        int'(occupancy) == $countones(slot_valid)
    );

    a_hold: assert property (
        @(posedge clk) disable iff (!rst_n)
        (out_valid & ~cxt_combine.ready)
        |=> (out_valid && $stable(out_head) && $stable(out_data))
    );
endmodule
